// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory initiator: funct3 encodings, sequencer states
// and the request classification helpers.
package mem_ctrl_pkg;

    localparam logic [2:0] CTRL_B  = 3'b000;
    localparam logic [2:0] CTRL_H  = 3'b001;
    localparam logic [2:0] CTRL_W  = 3'b010;
    localparam logic [2:0] CTRL_BU = 3'b100;
    localparam logic [2:0] CTRL_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        SEQ,
        RESP
    } seq_state_t;

    // Byte accesses can never be misaligned; halves need addr[0]=0, words addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] addr_lo);
        case (ctrl)
            CTRL_H, CTRL_HU: return addr_lo[0];
            CTRL_W:          return (addr_lo != 2'b00);
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_ctrl(input logic [2:0] ctrl, input logic we);
        case (ctrl)
            CTRL_B, CTRL_H, CTRL_W: return 1'b1;
            CTRL_BU, CTRL_HU:       return !we;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extender.sv
// Extends an LSB-aligned byte/half load to 32 bits according to its funct3.
module load_extender
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]  ctrl_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (ctrl_i)
            CTRL_B:  data_o = {{24{data_i[7]}}, data_i[7:0]};
            CTRL_H:  data_o = {{16{data_i[15]}}, data_i[15:0]};
            CTRL_BU: data_o = {24'h000000, data_i[7:0]};
            CTRL_HU: data_o = {16'h0000, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Data-memory initiator: issues aligned accesses directly and splits misaligned
// halfword/word accesses into one byte access per cycle.
module mem_access_sequencer
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [2:0]               req_ctrl,
    input  logic                     req_we,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic [2:0]               mem_ctrl,
    output logic                     mem_write_enable,
    input  logic [DATA_WIDTH-1:0]    mem_read_data
);

    seq_state_t               state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [2:0]               ctrl_q, ctrl_d;
    logic                     we_q, we_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [1:0]               last_q, last_d;
    logic [DATA_WIDTH-1:0]    asm_q, asm_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     err_q, err_d;

    logic                     req_legal;
    logic                     req_misaligned;
    logic [DATA_WIDTH-1:0]    asm_merged;
    logic [DATA_WIDTH-1:0]    asm_ext;
    logic [7:0]               wbyte;

    assign req_legal      = is_legal_ctrl(req_ctrl, req_we);
    assign req_misaligned = is_misaligned(req_ctrl, req_addr[1:0]);
    assign wbyte          = wdata_q[{cnt_q, 3'b000} +: 8];

    // Assembly image including the byte being read this cycle, so the final
    // SEQ cycle can extend the complete value without an extra stage.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_asm
            assign asm_merged[gi*8 +: 8] = (cnt_q == 2'(gi)) ? mem_read_data[7:0]
                                                             : asm_q[gi*8 +: 8];
        end
    endgenerate

    load_extender u_load_extender (
        .ctrl_i (ctrl_q),
        .data_i (asm_merged),
        .data_o (asm_ext)
    );

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        ctrl_d           = ctrl_q;
        we_d             = we_q;
        cnt_d            = cnt_q;
        last_d           = last_q;
        asm_d            = asm_q;
        rdata_d          = rdata_q;
        err_d            = err_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        resp_rdata       = '0;
        resp_err         = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_ctrl         = CTRL_W;
        mem_write_enable = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready      = 1'b1;
                mem_address    = req_addr;
                mem_write_data = req_wdata;
                mem_ctrl       = req_ctrl;
                if (req_valid) begin
                    if (!req_legal) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else if (!req_misaligned) begin
                        mem_write_enable = req_we;
                        rdata_d          = req_we ? '0 : mem_read_data;
                        err_d            = 1'b0;
                        state_d          = RESP;
                    end else begin
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        ctrl_d  = req_ctrl;
                        we_d    = req_we;
                        cnt_d   = 2'd0;
                        last_d  = (req_ctrl == CTRL_W) ? 2'd3 : 2'd1;
                        asm_d   = '0;
                        err_d   = 1'b0;
                        state_d = SEQ;
                    end
                end
            end
            SEQ: begin
                mem_address      = addr_q + {{(ADDRESS_WIDTH-2){1'b0}}, cnt_q};
                mem_ctrl         = we_q ? CTRL_B : CTRL_BU;
                mem_write_data   = {{(DATA_WIDTH-8){1'b0}}, wbyte};
                mem_write_enable = we_q;
                asm_d            = asm_merged;
                cnt_d            = cnt_q + 2'd1;
                if (cnt_q == last_q) begin
                    rdata_d = we_q ? '0 : asm_ext;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset must also suppress the write of the cycle it is sampled in.
        if (rst) begin
            mem_address      = '0;
            mem_write_data   = '0;
            mem_ctrl         = CTRL_W;
            mem_write_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            ctrl_q  <= CTRL_W;
            we_q    <= 1'b0;
            cnt_q   <= 2'd0;
            last_q  <= 2'd0;
            asm_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ctrl_q  <= ctrl_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench: byte-array memory model, per-request expectation queue, cycle compare.
module tb_mem_access_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_ctrl;
    logic        req_we;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [2:0]  mem_ctrl;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    mem_access_sequencer #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_ctrl         (req_ctrl),
        .req_we           (req_we),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_ctrl         (mem_ctrl),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    // 256-byte memoryunit model; address bits above 7 alias.
    logic [7:0] mem_m [0:255];
    logic [7:0] b0, b1, b2, b3;
    assign b0 = mem_m[mem_address[7:0]];
    assign b1 = mem_m[mem_address[7:0] + 8'd1];
    assign b2 = mem_m[mem_address[7:0] + 8'd2];
    assign b3 = mem_m[mem_address[7:0] + 8'd3];

    always_comb begin
        case (mem_ctrl)
            3'b000:  mem_read_data = {{24{b0[7]}}, b0};
            3'b100:  mem_read_data = {24'h0, b0};
            3'b001:  mem_read_data = {{16{b1[7]}}, b1, b0};
            3'b101:  mem_read_data = {16'h0, b1, b0};
            default: mem_read_data = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem_m[mem_address[7:0]] <= mem_write_data[7:0];
            if (mem_ctrl[1:0] != 2'b00)
                mem_m[mem_address[7:0] + 8'd1] <= mem_write_data[15:8];
            if (mem_ctrl[1:0] == 2'b10) begin
                mem_m[mem_address[7:0] + 8'd2] <= mem_write_data[23:16];
                mem_m[mem_address[7:0] + 8'd3] <= mem_write_data[31:24];
            end
        end
    end

    typedef struct packed {
        logic        chk_ready;
        logic        ready;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        chk_mem;
        logic [31:0] addr;
        logic [2:0]  ctrl;
        logic        we;
        logic [31:0] wmask;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t mk(input logic chk_ready, input logic ready, input logic rv,
                                input logic [31:0] rdata, input logic err, input logic chk_mem,
                                input logic [31:0] addr, input logic [2:0] ctrl, input logic we,
                                input logic [31:0] wmask, input logic [31:0] wdata);
        exp_t e;
        e.chk_ready = chk_ready; e.ready = ready; e.rv = rv; e.rdata = rdata; e.err = err;
        e.chk_mem = chk_mem; e.addr = addr; e.ctrl = ctrl; e.we = we;
        e.wmask = wmask; e.wdata = wdata;
        return e;
    endfunction

    // Reference load: gather bytes little-endian from the model memory and extend by funct3.
    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] ctrl);
        logic [31:0] v;
        logic [31:0] a;
        int          size;
        v    = 32'h0;
        size = (ctrl[1:0] == 2'd0) ? 1 : (ctrl[1:0] == 2'd1) ? 2 : 4;
        for (int i = 0; i < size; i++) begin
            a = addr + 32'(i);
            v[8*i +: 8] = mem_m[a[7:0]];
        end
        if (ctrl == 3'b000 && v[7])  v[31:8]  = 24'hFFFFFF;
        if (ctrl == 3'b001 && v[15]) v[31:16] = 16'hFFFF;
        return v;
    endfunction

    // Compare process: one expectation record per cycle while a request is in flight,
    // otherwise the idle invariants.
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                last_rdata = resp_rdata;
                last_err   = resp_err;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_ready) chk("req_ready", {31'h0, req_ready}, {31'h0, e.ready});
                chk("resp_valid", {31'h0, resp_valid}, {31'h0, e.rv});
                if (e.rv) begin
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                end
                chk("mem_write_enable", {31'h0, mem_write_enable}, {31'h0, e.we});
                if (e.chk_mem) begin
                    chk("mem_address", mem_address, e.addr);
                    chk("mem_ctrl", {29'h0, mem_ctrl}, {29'h0, e.ctrl});
                    chk("mem_write_data", mem_write_data & e.wmask, e.wdata & e.wmask);
                end
            end else begin
                chk("idle_ready", {31'h0, req_ready}, 32'h1);
                chk("idle_resp_valid", {31'h0, resp_valid}, 32'h0);
                chk("idle_mem_we", {31'h0, mem_write_enable}, 32'h0);
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [2:0] ctrl, input logic we,
                          input logic [31:0] wdata);
        logic        legal;
        logic        aligned;
        int          size;
        logic [31:0] exp_rd;
        legal   = we ? (ctrl inside {3'b000, 3'b001, 3'b010})
                     : (ctrl inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        size    = (ctrl[1:0] == 2'd0) ? 1 : (ctrl[1:0] == 2'd1) ? 2 : 4;
        aligned = ((addr & 32'(size - 1)) == 32'h0);
        exp_rd  = (legal && !we) ? model_load(addr, ctrl) : 32'h0;

        @(posedge clk);
        #1;
        req_addr  = addr;
        req_ctrl  = ctrl;
        req_we    = we;
        req_wdata = wdata;
        req_valid = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, legal && aligned, addr, ctrl,
                           legal && aligned && we, we ? 32'hFFFFFFFF : 32'h0, wdata));
        if (legal && !aligned) begin
            for (int k = 0; k < size; k++)
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, addr + 32'(k),
                                   we ? 3'b000 : 3'b100, we, 32'h000000FF,
                                   {24'h0, wdata[8*k +: 8]}));
        end
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, exp_rd, !legal, 1'b0, 32'h0, 3'b000, 1'b0,
                           32'h0, 32'h0));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_drain(12);
        $display("req addr=%h ctrl=%b we=%0d wdata=%h -> rdata=%h err=%0d",
                 addr, ctrl, we, wdata, last_rdata, last_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        mem_m[8'h10] = 8'hEF; mem_m[8'h11] = 8'hBE; mem_m[8'h12] = 8'hAD; mem_m[8'h13] = 8'hDE;
        mem_m[8'h20] = 8'hAA;
        mem_m[8'h03] = 8'h80; mem_m[8'h04] = 8'hFF;
        mem_m[8'hFE] = 8'h01; mem_m[8'hFF] = 8'h02; mem_m[8'h00] = 8'h03; mem_m[8'h01] = 8'h04;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h12345678;
        req_wdata = 32'hFFFFFFFF;
        req_ctrl  = 3'b001;
        req_we    = 1'b1;

        // Reset values, with non-zero request inputs to show the memory port is forced.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_ctrl", {29'h0, mem_ctrl}, 32'h2);
        chk("rst_mem_write_data", mem_write_data, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle without valid: address follows req_addr, no write even with req_we=1.
        @(negedge clk);
        chk("idle_addr_follow", mem_address, 32'h12345678);
        req_we = 1'b0;

        // 1. aligned LW
        do_req(32'h10, 3'b010, 1'b0, 32'h0);
        chk("t1_lw_lit", last_rdata, 32'hDEADBEEF);

        // 2. misaligned SW, then aligned LW over the merged bytes
        do_req(32'h21, 3'b010, 1'b1, 32'h11223344);
        chk("t2_b21", {24'h0, mem_m[8'h21]}, 32'h44);
        chk("t2_b22", {24'h0, mem_m[8'h22]}, 32'h33);
        chk("t2_b23", {24'h0, mem_m[8'h23]}, 32'h22);
        chk("t2_b24", {24'h0, mem_m[8'h24]}, 32'h11);
        do_req(32'h20, 3'b010, 1'b0, 32'h0);
        chk("t2_lw_lit", last_rdata, 32'h223344AA);

        // 3. misaligned LH / LHU
        do_req(32'h03, 3'b001, 1'b0, 32'h0);
        chk("t3_lh_lit", last_rdata, 32'hFFFFFF80);
        do_req(32'h03, 3'b101, 1'b0, 32'h0);
        chk("t3_lhu_lit", last_rdata, 32'h0000FF80);

        // 4. wrapping misaligned LW
        do_req(32'hFFFFFFFE, 3'b010, 1'b0, 32'h0);
        chk("t4_wrap_lit", last_rdata, 32'h04030201);

        // 5. illegal controls
        do_req(32'h10, 3'b011, 1'b0, 32'h0);
        chk("t5_ld011_err", {31'h0, last_err}, 32'h1);
        do_req(32'h60, 3'b100, 1'b1, 32'h000000AB);
        chk("t5_sb100_err", {31'h0, last_err}, 32'h1);
        chk("t5_no_write", {24'h0, mem_m[8'h60]}, 32'h0);
        do_req(32'h10, 3'b111, 1'b0, 32'h0);
        do_req(32'h60, 3'b101, 1'b1, 32'h0000ABCD);

        // Further aligned/misaligned mixes
        do_req(32'h40, 3'b001, 1'b1, 32'h5555BEEF);
        do_req(32'h40, 3'b001, 1'b0, 32'h0);
        chk("x_lh_aligned_lit", last_rdata, 32'hFFFFBEEF);
        do_req(32'h45, 3'b001, 1'b1, 32'h00001234);
        do_req(32'h45, 3'b101, 1'b0, 32'h0);
        chk("x_lhu_mis_lit", last_rdata, 32'h00001234);
        do_req(32'h10, 3'b000, 1'b0, 32'h0);
        chk("x_lb_lit", last_rdata, 32'hFFFFFFEF);
        do_req(32'h11, 3'b100, 1'b0, 32'h0);
        chk("x_lbu_lit", last_rdata, 32'h000000BE);
        do_req(32'h53, 3'b000, 1'b1, 32'hFFFFFF7A);
        do_req(32'h53, 3'b100, 1'b0, 32'h0);
        chk("x_sb_lbu_lit", last_rdata, 32'h0000007A);
        do_req(32'h07, 3'b010, 1'b1, 32'hCAFEF00D);
        do_req(32'h07, 3'b010, 1'b0, 32'h0);
        chk("x_sw_lw_mis_lit", last_rdata, 32'hCAFEF00D);

        // 6. reset during a misaligned SW after byte 0 has been written
        @(posedge clk);
        #1;
        req_addr  = 32'h31;
        req_ctrl  = 3'b010;
        req_we    = 1'b1;
        req_wdata = 32'hA1B2C3D4;
        req_valid = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0,
                           32'h0, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h31, 3'b000, 1'b1,
                           32'h000000FF, 32'h000000D4));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0,
                           32'h0, 32'h0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ready_after_rst", {31'h0, req_ready}, 32'h1);
        chk("t6_b31", {24'h0, mem_m[8'h31]}, 32'hD4);
        chk("t6_b32", {24'h0, mem_m[8'h32]}, 32'h00);
        chk("t6_b33", {24'h0, mem_m[8'h33]}, 32'h00);
        $display("req addr=00000031 ctrl=010 we=1 wdata=a1b2c3d4 -> interrupted by reset");
        do_req(32'h31, 3'b000, 1'b0, 32'h0);
        chk("t6_lb_lit", last_rdata, 32'hFFFFFFD4);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
